// File: rtl/mem_pkg.sv
// Shared widths and enumerations for the cache/main-memory arbiter.
package mem_pkg;
  localparam int ADDR_W = 26;
  localparam int LINE_W = 128;

  typedef enum {IDLE, BUSY, RESP} mem_state_e;
  typedef enum logic {ICACHE, DCACHE} mem_req_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side handshakes and RAM-side bus of the memory arbiter.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_ready;
  logic [LINE_W-1:0] dc_rdata;

  logic              mem_reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_we;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_ready, ic_rdata, dc_ready, dc_rdata,
           mem_reset, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_ready, ic_rdata, dc_ready, dc_rdata,
           mem_reset, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_rr_arb2.sv
// Two-input round-robin grant; a tie goes to whoever was not granted last.
module mem_rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  mem_req_e   last_grant,
  output logic       gnt_vld,
  output mem_req_e   gnt
);
  always_comb begin
    gnt_vld = |req;
    gnt     = ICACHE;
    if (req == 2'b11)
      gnt = (last_grant == ICACHE) ? DCACHE : ICACHE;
    else if (req[1])
      gnt = DCACHE;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line accesses onto one RAM with a fixed
// emulated latency of LATENCY cycles per access.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  mem_req_e         last_grant;
  mem_req_e         owner;
  logic             op_we;
  logic             gnt_vld;
  mem_req_e         gnt;
  logic             last_cycle;

  mem_rr_arb2 u_arb (
    .req       ({bus.dc_req, bus.ic_req}),
    .last_grant(last_grant),
    .gnt_vld   (gnt_vld),
    .gnt       (gnt)
  );

  assign last_cycle    = (cnt == CNT_W'(LATENCY - 1));
  // Decoded from registers only, so the write strobe is a clean single cycle.
  assign bus.mem_we    = op_we && (state == BUSY) && last_cycle;
  assign bus.mem_reset = reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= DCACHE;
      owner         <= ICACHE;
      op_we         <= 1'b0;
      bus.ic_ready  <= 1'b0;
      bus.dc_ready  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.ic_rdata  <= '0;
      bus.dc_rdata  <= '0;
    end else begin
      bus.ic_ready <= 1'b0;
      bus.dc_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner      <= gnt;
            last_grant <= gnt;
            cnt        <= '0;
            state      <= BUSY;
            if (gnt == ICACHE) begin
              bus.mem_addr <= bus.ic_addr;
              op_we        <= 1'b0;
            end else begin
              bus.mem_addr  <= bus.dc_addr;
              bus.mem_wdata <= bus.dc_wdata;
              op_we         <= bus.dc_we;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (last_cycle) begin
            state <= RESP;
            if (owner == ICACHE) begin
              bus.ic_ready <= 1'b1;
              if (!op_we) bus.ic_rdata <= bus.mem_rdata;
            end else begin
              bus.dc_ready <= 1'b1;
              if (!op_we) bus.dc_rdata <= bus.mem_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=5 instance on a small RAM model
// and a LATENCY=1 instance on a pattern-only RAM.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.LATENCY(5)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_arbiter #(.LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line k holds words 4k..4k+3, word 0 in the low 32 bits.
  function automatic logic [127:0] line_pat(input int k);
    return {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
  endfunction

  logic [127:0] ram [0:15];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= line_pat(i);
    end else if (bus_a.mem_we) begin
      ram[bus_a.mem_addr[3:0]] <= bus_a.mem_wdata;
    end
  end
  assign bus_a.mem_rdata = ram[bus_a.mem_addr[3:0]];
  assign bus_b.mem_rdata = line_pat(int'(bus_b.mem_addr[3:0]));

  // Watches dut_a for cycles c_first..c_last (cycle 0 = the IDLE cycle in which
  // the request is first presented); drops each req in its ready cycle.
  task automatic observe(input int c_first, input int c_last,
                         output int ic_cyc, output int ic_n,
                         output int dc_cyc, output int dc_n,
                         output int we_first, output int we_n,
                         output logic [127:0] ic_d, output logic [127:0] dc_d);
    ic_cyc = -1; ic_n = 0; dc_cyc = -1; dc_n = 0; we_first = -1; we_n = 0;
    ic_d = '0; dc_d = '0;
    for (int c = c_first; c <= c_last; c++) begin
      @(negedge clk);
      if (bus_a.ic_ready === 1'b1) begin
        if (ic_cyc < 0) begin ic_cyc = c; ic_d = bus_a.ic_rdata; end
        ic_n++;
        bus_a.ic_req = 1'b0;
      end
      if (bus_a.dc_ready === 1'b1) begin
        if (dc_cyc < 0) begin dc_cyc = c; dc_d = bus_a.dc_rdata; end
        dc_n++;
        bus_a.dc_req = 1'b0;
      end
      if (bus_a.mem_we === 1'b1) begin
        if (we_first < 0) we_first = c;
        we_n++;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_a.ic_req = 1'b1; bus_a.dc_req = 1'b1;
    bus_a.ic_addr = 26'h5; bus_a.dc_addr = 26'h6; bus_a.dc_wdata = {4{32'h1234_5678}};
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_a.ic_ready !== 1'b0) begin failures++; $display("FAIL reset_ic_ready got=%0b exp=0", bus_a.ic_ready); end
    checks++; if (bus_a.dc_ready !== 1'b0) begin failures++; $display("FAIL reset_dc_ready got=%0b exp=0", bus_a.dc_ready); end
    checks++; if (bus_a.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", bus_a.mem_we); end
    checks++; if (bus_a.mem_addr !== 26'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", bus_a.mem_addr); end
    checks++; if (bus_a.mem_wdata !== 128'h0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus_a.mem_wdata); end
    checks++; if ((bus_a.ic_rdata | bus_a.dc_rdata) !== 128'h0) begin failures++; $display("FAIL reset_rdata got=%0h/%0h exp=0", bus_a.ic_rdata, bus_a.dc_rdata); end
    checks++; if (bus_a.mem_reset !== 1'b1) begin failures++; $display("FAIL reset_mem_reset_hi got=%0b exp=1", bus_a.mem_reset); end
    bus_a.ic_req = 1'b0; bus_a.dc_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.mem_reset !== 1'b0) begin failures++; $display("FAIL reset_mem_reset_lo got=%0b exp=0", bus_a.mem_reset); end
    checks++; if (dut_a.state !== IDLE) begin failures++; $display("FAIL reset_no_grant state=%0d exp=%0d", dut_a.state, IDLE); end
  endtask

  task automatic test_ic_read();
    int ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n;
    logic [127:0] ic_d, dc_d;
    bus_a.ic_addr = 26'h0000004;
    bus_a.ic_req  = 1'b1;
    observe(1, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (ic_cyc !== 6) begin failures++; $display("FAIL ic_read_cycle got=%0d exp=6", ic_cyc); end
    checks++; if (ic_n !== 1) begin failures++; $display("FAIL ic_read_pulses got=%0d exp=1", ic_n); end
    checks++; if (ic_d !== {32'd19, 32'd18, 32'd17, 32'd16}) begin failures++; $display("FAIL ic_read_data got=%0h exp=%0h", ic_d, {32'd19, 32'd18, 32'd17, 32'd16}); end
    checks++; if (dc_n !== 0) begin failures++; $display("FAIL ic_read_dc_ready got=%0d exp=0", dc_n); end
    checks++; if (we_n !== 0) begin failures++; $display("FAIL ic_read_we got=%0d exp=0", we_n); end
    checks++; if (bus_a.mem_addr !== 26'h4) begin failures++; $display("FAIL ic_read_addr_hold got=%0h exp=4", bus_a.mem_addr); end
  endtask

  task automatic test_dc_write_read();
    int ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n;
    logic [127:0] ic_d, dc_d;
    bus_a.dc_addr  = 26'h2;
    bus_a.dc_wdata = {4{32'hAAAA_AAAA}};
    bus_a.dc_we    = 1'b1;
    bus_a.dc_req   = 1'b1;
    observe(1, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (we_first !== 5) begin failures++; $display("FAIL dc_write_we_cycle got=%0d exp=5", we_first); end
    checks++; if (we_n !== 1) begin failures++; $display("FAIL dc_write_we_count got=%0d exp=1", we_n); end
    checks++; if (dc_cyc !== 6) begin failures++; $display("FAIL dc_write_ready got=%0d exp=6", dc_cyc); end
    checks++; if (dc_d !== 128'h0) begin failures++; $display("FAIL dc_write_rdata_kept got=%0h exp=0", dc_d); end
    checks++; if (bus_a.mem_wdata !== {4{32'hAAAA_AAAA}}) begin failures++; $display("FAIL dc_write_wdata got=%0h exp=aa..aa", bus_a.mem_wdata); end
    bus_a.dc_we  = 1'b0;
    bus_a.dc_req = 1'b1;
    observe(1, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (dc_cyc !== 6) begin failures++; $display("FAIL dc_read_ready got=%0d exp=6", dc_cyc); end
    checks++; if (dc_d !== {4{32'hAAAA_AAAA}}) begin failures++; $display("FAIL dc_read_data got=%0h exp=aa..aa", dc_d); end
    checks++; if (we_n !== 0) begin failures++; $display("FAIL dc_read_we got=%0d exp=0", we_n); end
  endtask

  task automatic test_tie();
    int ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n;
    logic [127:0] ic_d, dc_d;
    pulse_reset();
    bus_a.ic_addr = 26'h1; bus_a.dc_addr = 26'h3; bus_a.dc_we = 1'b0;
    bus_a.ic_req = 1'b1; bus_a.dc_req = 1'b1;
    observe(1, 16, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (ic_cyc !== 6) begin failures++; $display("FAIL tie1_ic_ready got=%0d exp=6", ic_cyc); end
    checks++; if (dc_cyc !== 13) begin failures++; $display("FAIL tie1_dc_ready got=%0d exp=13", dc_cyc); end
    checks++; if (ic_d !== line_pat(1)) begin failures++; $display("FAIL tie1_ic_data got=%0h exp=%0h", ic_d, line_pat(1)); end
    checks++; if (dc_d !== line_pat(3)) begin failures++; $display("FAIL tie1_dc_data got=%0h exp=%0h", dc_d, line_pat(3)); end
    // DCACHE was granted last, so ICACHE wins again.
    bus_a.ic_req = 1'b1; bus_a.dc_req = 1'b1;
    observe(1, 16, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (ic_cyc !== 6 || dc_cyc !== 13) begin failures++; $display("FAIL tie2_order got=ic%0d/dc%0d exp=ic6/dc13", ic_cyc, dc_cyc); end
    bus_a.ic_addr = 26'h5; bus_a.ic_req = 1'b1;
    observe(1, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    // ICACHE was granted last, so DCACHE wins the tie.
    bus_a.ic_req = 1'b1; bus_a.dc_req = 1'b1;
    observe(1, 16, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (dc_cyc !== 6 || ic_cyc !== 13) begin failures++; $display("FAIL tie3_order got=dc%0d/ic%0d exp=dc6/ic13", dc_cyc, ic_cyc); end
    checks++; if (ic_d !== line_pat(5)) begin failures++; $display("FAIL tie3_ic_data got=%0h exp=%0h", ic_d, line_pat(5)); end
  endtask

  task automatic test_addr_change();
    int ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n;
    logic [127:0] ic_d, dc_d;
    bus_a.dc_addr = 26'h7; bus_a.dc_we = 1'b0; bus_a.dc_req = 1'b1;
    observe(1, 2, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    bus_a.dc_addr = 26'h9;
    observe(3, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (bus_a.mem_addr !== 26'h7) begin failures++; $display("FAIL addr_change_mem_addr got=%0h exp=7", bus_a.mem_addr); end
    checks++; if (dc_cyc !== 6) begin failures++; $display("FAIL addr_change_ready got=%0d exp=6", dc_cyc); end
    checks++; if (dc_d !== line_pat(7)) begin failures++; $display("FAIL addr_change_data got=%0h exp=%0h", dc_d, line_pat(7)); end
  endtask

  task automatic test_reset_mid();
    int ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n;
    logic [127:0] ic_d, dc_d;
    bus_a.ic_addr = 26'h6; bus_a.ic_req = 1'b1;
    observe(1, 3, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    reset = 1'b1;
    bus_a.ic_req = 1'b0;
    @(negedge clk);
    checks++; if (dut_a.state !== IDLE) begin failures++; $display("FAIL reset_mid_state got=%0d exp=%0d", dut_a.state, IDLE); end
    checks++; if (bus_a.mem_addr !== 26'h0) begin failures++; $display("FAIL reset_mid_mem_addr got=%0h exp=0", bus_a.mem_addr); end
    reset = 1'b0;
    observe(5, 12, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (ic_n !== 0 || dc_n !== 0) begin failures++; $display("FAIL reset_mid_no_ready got=ic%0d/dc%0d exp=0/0", ic_n, dc_n); end
    bus_a.ic_req = 1'b1;
    observe(1, 10, ic_cyc, ic_n, dc_cyc, dc_n, we_first, we_n, ic_d, dc_d);
    checks++; if (ic_cyc !== 6) begin failures++; $display("FAIL reset_mid_reissue_ready got=%0d exp=6", ic_cyc); end
    checks++; if (ic_d !== line_pat(6)) begin failures++; $display("FAIL reset_mid_reissue_data got=%0h exp=%0h", ic_d, line_pat(6)); end
  endtask

  task automatic test_latency1();
    int rdy_cyc, we_cyc, we_n;
    logic [127:0] d;
    rdy_cyc = -1; d = '0;
    bus_b.ic_addr = 26'h4; bus_b.ic_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus_b.ic_ready === 1'b1 && rdy_cyc < 0) begin
        rdy_cyc = c; d = bus_b.ic_rdata; bus_b.ic_req = 1'b0;
      end
    end
    checks++; if (rdy_cyc !== 2) begin failures++; $display("FAIL lat1_read_ready got=%0d exp=2", rdy_cyc); end
    checks++; if (d !== {32'd19, 32'd18, 32'd17, 32'd16}) begin failures++; $display("FAIL lat1_read_data got=%0h exp=%0h", d, {32'd19, 32'd18, 32'd17, 32'd16}); end
    rdy_cyc = -1; we_cyc = -1; we_n = 0;
    bus_b.dc_addr = 26'h3; bus_b.dc_we = 1'b1; bus_b.dc_wdata = {4{32'h5555_5555}};
    bus_b.dc_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus_b.mem_we === 1'b1) begin
        if (we_cyc < 0) we_cyc = c;
        we_n++;
      end
      if (bus_b.dc_ready === 1'b1 && rdy_cyc < 0) begin
        rdy_cyc = c; bus_b.dc_req = 1'b0;
      end
    end
    checks++; if (we_cyc !== 1 || we_n !== 1) begin failures++; $display("FAIL lat1_write_we got=cyc%0d/n%0d exp=cyc1/n1", we_cyc, we_n); end
    checks++; if (rdy_cyc !== 2) begin failures++; $display("FAIL lat1_write_ready got=%0d exp=2", rdy_cyc); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus_a.ic_req = 1'b0; bus_a.ic_addr = '0;
    bus_a.dc_req = 1'b0; bus_a.dc_we = 1'b0; bus_a.dc_addr = '0; bus_a.dc_wdata = '0;
    bus_b.ic_req = 1'b0; bus_b.ic_addr = '0;
    bus_b.dc_req = 1'b0; bus_b.dc_we = 1'b0; bus_b.dc_addr = '0; bus_b.dc_wdata = '0;
    test_reset();
    test_ic_read();
    test_dc_write_read();
    test_tie();
    test_addr_change();
    test_reset_mid();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
